apb_i2c_bridge: RTL and testbench
=================================

# apb_i2c_bridge

APB3 slave register front end that sits directly upstream of the I2C master. Software programs a target address, write data and direction through APB registers; the bridge then drives the master's command interface (`ce`, `rden`, `wren`, `addr`, `wdata`), holds `ce` for the whole transfer, and captures completion, read data and error status. It also raises an interrupt on completion or error.

## Interface
- `TIMEOUT_CYCLES`, default 4096: `clk` cycles allowed in WAIT before abort (used only with `I2C_TIMEOUT_EN`).
- `clk  input  1`: system clock; all logic is on the rising edge.
- `reset  input  1`: synchronous, active-low reset.
- `psel  input  1`: APB select.
- `penable  input  1`: APB access phase.
- `pwrite  input  1`: APB direction; 1 = write.
- `paddr  input  5`: byte address; bits [1:0] are ignored.
- `pwdata  input  32`: APB write data.
- `prdata  output  32`: APB read data.
- `pready  output  1`: APB ready.
- `pslverr  output  1`: APB error.
- `i2c_ce  output  1`: master enable; held high for the whole transfer.
- `i2c_rden  output  1`: read transfer.
- `i2c_wren  output  1`: write transfer.
- `i2c_addr  output  8`: {slave[7:6], mem[5:0]}.
- `i2c_wdata  output  8`: write byte.
- `i2c_done  input  1`: master finished its stop condition; 1-cycle pulse or level.
- `i2c_error  input  1`: master error or NACK.
- `i2c_rdata  input  8`: byte received by the master.
- `irq  output  1`: level interrupt.

## Operation
Registers, selected by `paddr[4:2]`:
- 0 CTRL (RW): bit0 START (write-1 self-clearing, reads 0), bit1 RW (1 = read), bit2 IE.
- 1 ADDR (RW) [7:0].
- 2 WDATA (RW) [7:0].
- 3 RDATA (RO) [7:0].
- 4 STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bit3 TIMEOUT (W1C).
- Unused register bits read 0.

APB rules:
- Zero wait state: `pready` = 1 in every access phase (`psel & penable`).
- `pslverr` = 1 for:
  - `paddr[4:2]` greater than 4;
  - a write to ADDR, WDATA, or CTRL with START=1 while BUSY.
- A write flagged with `pslverr` has no effect. A read from an unmapped address returns 0.

FSM states:
- **IDLE**: `i2c_ce` = 0. A CTRL write with START=1 latches ADDR, WDATA and RW into the output holding registers, clears DONE, ERR and TIMEOUT, and moves to WAIT.
- **WAIT**: `i2c_ce` = 1, with `i2c_rden` = RW and `i2c_wren` = !RW. Outputs are stable for the whole state.
  - `i2c_error` → ERR = 1, go to COMPLETE.
  - `i2c_done` without `i2c_error` → DONE = 1; if RW = 1, also RDATA ← `i2c_rdata`. Go to COMPLETE.
  - `i2c_error` has priority when both are high in the same cycle.
- **COMPLETE**: `i2c_ce` = 0 for exactly one cycle, then IDLE. START is ignored (`pslverr`) in this state.

Other rules:
- BUSY = (state != IDLE).
- `irq` = IE & (DONE | ERR).
- An APB W1C write to STATUS in the same cycle as a hardware set: the hardware set wins.

## Timing
- Reset values:
  - `prdata`, `pslverr`, `i2c_ce`, `i2c_rden`, `i2c_wren`, `i2c_addr`, `i2c_wdata`, `irq` = 0; `pready` = 0 outside the access phase.
  - All registers = 0; state = IDLE.
- `prdata` and `pslverr` are combinational in the access phase.
- START write accepted at edge N → `i2c_ce` = 1 from N+1.
- `i2c_done`/`i2c_error` sampled at edge M → STATUS updated and `i2c_ce` = 0 from M+1; IDLE from M+2.
- Back-to-back: a START written at edge M+2 is accepted.
- Reset asserted mid-transfer: `i2c_ce` drops on the next edge and all status is cleared. The master flags `ce` loss itself.

## Configuration
- `I2C_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments every cycle in WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no done or error: ERR = 1, TIMEOUT = 1, go to COMPLETE.
- `I2C_TIMEOUT_EN` undefined:
  - No counter is built; WAIT lasts until done or error.
  - STATUS bit3 reads 0.

## Test plan
- Write ADDR = 0x85, WDATA = 0x3C, CTRL = 0x1 → next cycle `i2c_ce` = 1, `i2c_wren` = 1, `i2c_addr` = 0x85, `i2c_wdata` = 0x3C; pulse `i2c_done` → STATUS = 0x2, `i2c_ce` = 0.
- CTRL = 0x7 (read, IE), `i2c_rdata` = 0xA5 with `i2c_done` → RDATA reads 0xA5, STATUS = 0x2, `irq` = 1; write STATUS = 0x2 → `irq` = 0.
- During WAIT, write WDATA = 0xFF → `pslverr` = 1 and `i2c_wdata` is unchanged; read `paddr` = 0x18 → `prdata` = 0, `pslverr` = 1.
- `i2c_error` and `i2c_done` high in the same cycle → STATUS = 0x4, RDATA unchanged.
- With `I2C_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, START with no response → after 16 WAIT cycles, STATUS = 0xC and `i2c_ce` = 0.
- Reset low during WAIT → next edge `i2c_ce` = 0, STATUS = 0, and a new START is accepted after reset is released.

Source files
------------

// File: rtl/apb_i2c_bridge.sv
// APB3 register front end driving the I2C master command interface.
// Optional WAIT-state abort timer is built when I2C_TIMEOUT_EN is defined.
module apb_i2c_bridge #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [4:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        i2c_ce,
   output logic        i2c_rden,
   output logic        i2c_wren,
   output logic [7:0]  i2c_addr,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_done,
   input  logic        i2c_error,
   input  logic [7:0]  i2c_rdata,
   output logic        irq
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMPLETE} state_t;

   state_t      state;
   logic        rw_q, ie_q;
   logic [7:0]  addr_q, wdata_q, rdata_q;
   logic        done_q, err_q, tout_q;
   logic        access, wr, busy, unmapped, busy_err, wr_ok, start, clr_st;
   logic [2:0]  sel;
   logic        unused_ok;

`ifdef I2C_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt;
`endif

   assign sel      = paddr[4:2];
   assign access   = psel & penable;
   assign wr       = access & pwrite;
   assign busy     = (state != S_IDLE);
   assign unmapped = (sel > 3'd4);
   // Anything that would disturb the transfer in flight is refused while busy
   assign busy_err = wr & busy & ((sel == 3'd1) | (sel == 3'd2) | ((sel == 3'd0) & pwdata[0]));
   assign pslverr  = access & (unmapped | busy_err);
   assign pready   = access;
   assign wr_ok    = wr & ~pslverr;
   assign start    = wr_ok & (sel == 3'd0) & pwdata[0];
   assign clr_st   = wr_ok & (sel == 3'd4);
   assign irq      = ie_q & (done_q | err_q);
   assign unused_ok = ^{paddr[1:0], pwdata[31:8]};

   always_comb begin
      prdata = 32'd0;
      if (access && !unmapped) begin
         case (sel)
            3'd0:    prdata = {29'd0, ie_q, rw_q, 1'b0};
            3'd1:    prdata = {24'd0, addr_q};
            3'd2:    prdata = {24'd0, wdata_q};
            3'd3:    prdata = {24'd0, rdata_q};
            3'd4:    prdata = {28'd0, tout_q, err_q, done_q, busy};
            default: prdata = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         rw_q      <= 1'b0;
         ie_q      <= 1'b0;
         addr_q    <= 8'd0;
         wdata_q   <= 8'd0;
         rdata_q   <= 8'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tout_q    <= 1'b0;
         i2c_ce    <= 1'b0;
         i2c_rden  <= 1'b0;
         i2c_wren  <= 1'b0;
         i2c_addr  <= 8'd0;
         i2c_wdata <= 8'd0;
`ifdef I2C_TIMEOUT_EN
         to_cnt    <= 16'd0;
`endif
      end else begin
         if (wr_ok && sel == 3'd0) begin
            rw_q <= pwdata[1];
            ie_q <= pwdata[2];
         end
         if (wr_ok && sel == 3'd1) addr_q  <= pwdata[7:0];
         if (wr_ok && sel == 3'd2) wdata_q <= pwdata[7:0];
         // W1C first so a hardware set later in this block takes precedence
         if (clr_st) begin
            if (pwdata[1]) done_q <= 1'b0;
            if (pwdata[2]) err_q  <= 1'b0;
            if (pwdata[3]) tout_q <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  i2c_ce    <= 1'b1;
                  i2c_rden  <= pwdata[1];
                  i2c_wren  <= ~pwdata[1];
                  i2c_addr  <= addr_q;
                  i2c_wdata <= wdata_q;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  tout_q    <= 1'b0;
`ifdef I2C_TIMEOUT_EN
                  to_cnt    <= 16'd0;
`endif
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i2c_error) begin
                  err_q    <= 1'b1;
                  i2c_ce   <= 1'b0;
                  i2c_rden <= 1'b0;
                  i2c_wren <= 1'b0;
                  state    <= S_COMPLETE;
               end else if (i2c_done) begin
                  done_q <= 1'b1;
                  if (i2c_rden) rdata_q <= i2c_rdata;
                  i2c_ce   <= 1'b0;
                  i2c_rden <= 1'b0;
                  i2c_wren <= 1'b0;
                  state    <= S_COMPLETE;
               end
`ifdef I2C_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  err_q    <= 1'b1;
                  tout_q   <= 1'b1;
                  i2c_ce   <= 1'b0;
                  i2c_rden <= 1'b0;
                  i2c_wren <= 1'b0;
                  state    <= S_COMPLETE;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end
            S_COMPLETE: state <= S_IDLE;
            default:    state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_i2c_bridge.sv
// Bench for apb_i2c_bridge: register vector table, directed corner sequences,
// and randomized transfers checked against a transaction-level model.
module tb_apb_i2c_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        i2c_ce, i2c_rden, i2c_wren;
   logic [7:0]  i2c_addr, i2c_wdata;
   logic        i2c_done, i2c_error;
   logic [7:0]  i2c_rdata;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   apb_i2c_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .i2c_ce(i2c_ce), .i2c_rden(i2c_rden), .i2c_wren(i2c_wren), .i2c_addr(i2c_addr),
      .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_error(i2c_error),
      .i2c_rdata(i2c_rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1 err = pslverr;
      check("pready_wr", {31'd0, pready}, 32'd1);
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = 32'd0;
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata; err = pslverr;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic pulse(input logic d, input logic e, input logic [7:0] r);
      @(negedge clk);
      i2c_done = d; i2c_error = e; i2c_rdata = r;
      @(posedge clk);
      #1 i2c_done = 1'b0; i2c_error = 1'b0;
   endtask

   initial begin
      logic        err;
      logic [31:0] rd;
      logic [7:0]  model_rdata;
      logic [7:0]  ra, rw_d, rr;
      logic        rrw, rie;
      int          dly, kind;
      logic [31:0] exp_st;

      reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 5'd0; pwdata = 32'd0;
      i2c_done = 1'b0; i2c_error = 1'b0; i2c_rdata = 8'd0;
      model_rdata = 8'd0;

      vt[0]  = '{1'b0, 5'h00, 32'h0,         32'h0,  1'b0};
      vt[1]  = '{1'b0, 5'h10, 32'h0,         32'h0,  1'b0};
      vt[2]  = '{1'b1, 5'h04, 32'hFFFF_FF85, 32'h0,  1'b0};
      vt[3]  = '{1'b0, 5'h04, 32'h0,         32'h85, 1'b0};
      vt[4]  = '{1'b1, 5'h08, 32'h3C,        32'h0,  1'b0};
      vt[5]  = '{1'b0, 5'h08, 32'h0,         32'h3C, 1'b0};
      vt[6]  = '{1'b1, 5'h00, 32'h6,         32'h0,  1'b0};
      vt[7]  = '{1'b0, 5'h00, 32'h0,         32'h6,  1'b0};
      vt[8]  = '{1'b1, 5'h00, 32'h0,         32'h0,  1'b0};
      vt[9]  = '{1'b0, 5'h00, 32'h0,         32'h0,  1'b0};
      vt[10] = '{1'b0, 5'h0C, 32'h0,         32'h0,  1'b0};
      vt[11] = '{1'b0, 5'h18, 32'h0,         32'h0,  1'b1};
      vt[12] = '{1'b1, 5'h1C, 32'h1,         32'h0,  1'b1};
      vt[13] = '{1'b0, 5'h14, 32'h0,         32'h0,  1'b1};
      vt[14] = '{1'b0, 5'h07, 32'h0,         32'h85, 1'b0};
      vt[15] = '{1'b1, 5'h0C, 32'h55,        32'h0,  1'b0};
      vt[16] = '{1'b0, 5'h0C, 32'h0,         32'h0,  1'b0};
      vt[17] = '{1'b1, 5'h10, 32'h6,         32'h0,  1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_prdata", prdata, 32'd0);
      check("rst_pready", {31'd0, pready}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_ce", {31'd0, i2c_ce}, 32'd0);
      check("rst_rden_wren", {30'd0, i2c_rden, i2c_wren}, 32'd0);
      check("rst_addr_wdata", {16'd0, i2c_addr, i2c_wdata}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk); reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         if (vt[i].wr) begin
            apb_write(vt[i].a, vt[i].d, err);
         end else begin
            apb_read(vt[i].a, rd, err);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
         end
         check($sformatf("vec%0d_slverr", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      end

      // Write transfer with busy-time protection
      apb_write(5'h00, 32'h1, err);
      check("wr_start_err", {31'd0, err}, 32'd0);
      check("wr_ce", {31'd0, i2c_ce}, 32'd1);
      check("wr_dir", {30'd0, i2c_rden, i2c_wren}, 32'd1);
      check("wr_addr", {24'd0, i2c_addr}, 32'h85);
      check("wr_wdata", {24'd0, i2c_wdata}, 32'h3C);
      apb_read(5'h10, rd, err);
      check("wr_busy", rd, 32'h1);
      apb_write(5'h08, 32'hFF, err);
      check("busy_wdata_err", {31'd0, err}, 32'd1);
      check("busy_wdata_hold", {24'd0, i2c_wdata}, 32'h3C);
      apb_write(5'h04, 32'h11, err);
      check("busy_addr_err", {31'd0, err}, 32'd1);
      apb_write(5'h00, 32'h1, err);
      check("busy_start_err", {31'd0, err}, 32'd1);
      apb_read(5'h18, rd, err);
      check("busy_unmapped_rd", rd, 32'd0);
      check("busy_unmapped_err", {31'd0, err}, 32'd1);
      apb_read(5'h08, rd, err);
      check("busy_wdata_reg", rd, 32'h3C);
      pulse(1'b1, 1'b0, 8'h00);
      check("wr_done_ce", {31'd0, i2c_ce}, 32'd0);
      apb_read(5'h10, rd, err);
      check("wr_done_status", rd, 32'h2);
      check("wr_done_irq", {31'd0, irq}, 32'd0);

      // Read transfer with interrupt
      apb_write(5'h00, 32'h7, err);
      check("rd_dir", {30'd0, i2c_rden, i2c_wren}, 32'h2);
      pulse(1'b1, 1'b0, 8'hA5);
      model_rdata = 8'hA5;
      apb_read(5'h0C, rd, err);
      check("rd_rdata", rd, 32'hA5);
      apb_read(5'h10, rd, err);
      check("rd_status", rd, 32'h2);
      check("rd_irq", {31'd0, irq}, 32'd1);
      apb_write(5'h10, 32'h2, err);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      apb_read(5'h10, rd, err);
      check("w1c_status", rd, 32'h0);

      // Error wins over done
      apb_write(5'h00, 32'h7, err);
      pulse(1'b1, 1'b1, 8'h11);
      apb_read(5'h10, rd, err);
      check("both_status", rd, 32'h4);
      apb_read(5'h0C, rd, err);
      check("both_rdata", rd, {24'd0, model_rdata});
      check("both_irq", {31'd0, irq}, 32'd1);
      apb_write(5'h10, 32'h4, err);
      check("both_clr_irq", {31'd0, irq}, 32'd0);

      // START presented while COMPLETE is refused
      apb_write(5'h00, 32'h1, err);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h1; i2c_done = 1'b1;
      @(posedge clk);
      #1 i2c_done = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1 check("complete_start_err", {31'd0, pslverr}, 32'd1);
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
      check("complete_ce", {31'd0, i2c_ce}, 32'd0);
      apb_read(5'h10, rd, err);
      check("complete_status", rd, 32'h2);

      // Back-to-back START two edges after done
      apb_write(5'h00, 32'h1, err);
      pulse(1'b1, 1'b0, 8'h00);
      apb_write(5'h00, 32'h1, err);
      check("b2b_err", {31'd0, err}, 32'd0);
      check("b2b_ce", {31'd0, i2c_ce}, 32'd1);

      // W1C of DONE on the same edge as hardware done
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h10; pwdata = 32'h6;
      @(negedge clk);
      penable = 1'b1; i2c_done = 1'b1;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0; i2c_done = 1'b0;
      apb_read(5'h10, rd, err);
      check("hw_set_wins", rd, 32'h2);

      // Reset during WAIT
      apb_write(5'h00, 32'h5, err);
      @(negedge clk); reset = 1'b0;
      @(posedge clk);
      #1 check("midrst_ce", {31'd0, i2c_ce}, 32'd0);
      @(negedge clk); reset = 1'b1;
      model_rdata = 8'd0;
      apb_read(5'h10, rd, err);
      check("midrst_status", rd, 32'h0);
      apb_read(5'h04, rd, err);
      check("midrst_addr", rd, 32'h0);
      apb_write(5'h04, 32'h42, err);
      apb_write(5'h00, 32'h1, err);
      check("midrst_restart_ce", {31'd0, i2c_ce}, 32'd1);
      check("midrst_restart_addr", {24'd0, i2c_addr}, 32'h42);
      pulse(1'b1, 1'b0, 8'h00);

`ifdef I2C_TIMEOUT_EN
      apb_write(5'h00, 32'h1, err);
      repeat (15) @(posedge clk);
      #1 check("to_still_waiting", {31'd0, i2c_ce}, 32'd1);
      @(posedge clk);
      #1 check("to_ce", {31'd0, i2c_ce}, 32'd0);
      apb_read(5'h10, rd, err);
      check("to_status", rd, 32'hC);
`else
      apb_write(5'h00, 32'h1, err);
      repeat (40) @(posedge clk);
      #1 check("noto_ce", {31'd0, i2c_ce}, 32'd1);
      apb_read(5'h10, rd, err);
      check("noto_status", rd, 32'h1);
      pulse(1'b1, 1'b0, 8'h00);
`endif

      // Randomized transfers against the transaction model
      for (int it = 0; it < 40; it++) begin
         ra   = 8'($urandom_range(0, 255));
         rw_d = 8'($urandom_range(0, 255));
         rr   = 8'($urandom_range(0, 255));
         rrw  = 1'($urandom_range(0, 1));
         rie  = 1'($urandom_range(0, 1));
         dly  = $urandom_range(0, 6);
         kind = $urandom_range(0, 2);
         apb_write(5'h04, {24'd0, ra}, err);
         apb_write(5'h08, {24'd0, rw_d}, err);
         apb_write(5'h00, {29'd0, rie, rrw, 1'b1}, err);
         check("rnd_start_err", {31'd0, err}, 32'd0);
         check("rnd_ce", {31'd0, i2c_ce}, 32'd1);
         check("rnd_dir", {30'd0, i2c_rden, i2c_wren}, {30'd0, rrw, ~rrw});
         check("rnd_addr", {24'd0, i2c_addr}, {24'd0, ra});
         check("rnd_wdata", {24'd0, i2c_wdata}, {24'd0, rw_d});
         i2c_rdata = ~rr;
         if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1 check("rnd_hold_ce", {31'd0, i2c_ce}, 32'd1);
         end
         pulse(kind != 1, kind != 0, rr);
         exp_st = (kind == 0) ? 32'h2 : 32'h4;
         if (kind == 0 && rrw) model_rdata = rr;
         check("rnd_done_ce", {31'd0, i2c_ce}, 32'd0);
         apb_read(5'h10, rd, err);
         check("rnd_status", rd, exp_st);
         apb_read(5'h0C, rd, err);
         check("rnd_rdata", rd, {24'd0, model_rdata});
         check("rnd_irq", {31'd0, irq}, {31'd0, rie});
         apb_write(5'h10, 32'h6, err);
         check("rnd_irq_clr", {31'd0, irq}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
